// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use scoreboard, taken-branch flush sequencing,
// memory freeze override and a saturating count of hazard-stall cycles.
module hazard_ctrl #(
    parameter int FlushCycles = 2,
    parameter int CntWidth    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [4:0]          id_rs1n,
    input  logic [4:0]          id_rs2n,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [4:0]          id_rdn,
    input  logic                id_is_load,
    input  logic                branch_taken,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rdn,
    input  logic                mem_ready,
    output logic                stall_if,
    output logic                stall_id,
    output logic                bubble_ex,
    output logic                flush_if_id,
    output logic [31:0]         busy,
    output logic [CntWidth-1:0] stall_cnt
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0] FlushLoad = 3'(FlushCycles);

    state_t      state, state_n;
    logic [2:0]  flush_cnt, flush_cnt_n;
    logic [31:0] clr, set, eff_busy, busy_n;
    logic        rs1_hit, rs2_hit, hazard, freeze, issue;

    // Scoreboard: a writeback in the same cycle releases the hazard it would cause.
    always_comb begin
        clr = '0;
        if (wb_valid) clr[wb_rdn] = 1'b1;
        eff_busy = busy & ~clr;
        rs1_hit  = id_rs1_used && (id_rs1n != 5'd0) && eff_busy[id_rs1n];
        rs2_hit  = id_rs2_used && (id_rs2n != 5'd0) && eff_busy[id_rs2n];
        hazard   = id_valid && (state == RUN) && (rs1_hit || rs2_hit);
        freeze   = !mem_ready;
        issue    = id_valid && !hazard && !freeze && (state == RUN);
        set = '0;
        if (issue && id_is_load && (id_rdn != 5'd0)) set[id_rdn] = 1'b1;
        busy_n = (eff_busy | set) & ~32'd1;
    end

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        case (state)
            RUN: begin
                if (issue && branch_taken) begin
                    state_n     = FLUSH;
                    flush_cnt_n = FlushLoad;
                end
            end
            FLUSH: begin
                if (!freeze) begin
                    flush_cnt_n = flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1) state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    // Reset forces every control output low, ahead of freeze and flush.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        if (!rst) begin
            if (freeze) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (state == FLUSH) begin
                flush_if_id = 1'b1;
            end else if (hazard) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            busy      <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            busy      <= busy_n;
            if (hazard && !freeze && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CntWidth'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed stimulus for hazard_ctrl, checked against a
// behavioural model of the scoreboard, flush window and stall counter.
module tb_hazard_ctrl;

    localparam int FC = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, id_valid, id_rs1_used, id_rs2_used, id_is_load;
    logic          branch_taken, wb_valid, mem_ready;
    logic [4:0]    id_rs1n, id_rs2n, id_rdn, wb_rdn;
    logic          stall_if, stall_id, bubble_ex, flush_if_id;
    logic [31:0]   busy;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl #(.FlushCycles(FC), .CntWidth(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1n(id_rs1n), .id_rs2n(id_rs2n),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rdn(id_rdn), .id_is_load(id_is_load), .branch_taken(branch_taken),
        .wb_valid(wb_valid), .wb_rdn(wb_rdn), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference: set of registers awaiting a load, remaining flush slots, stall total.
    bit pending[32];
    int flush_left;
    int stalls;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; id_valid = 1'b0; id_rs1n = '0; id_rs2n = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rdn = '0; id_is_load = 1'b0;
        branch_taken = 1'b0; wb_valid = 1'b0; wb_rdn = '0; mem_ready = 1'b1;
    endtask

    function automatic bit reads_pending(input bit used, input logic [4:0] r);
        if (!used || r == 5'd0) return 1'b0;
        if (wb_valid && wb_rdn == r) return 1'b0;
        return pending[r];
    endfunction

    // One clock with the stimulus variables already set.
    task automatic step();
        bit in_flush, frozen, stall_here;
        logic [3:0] exp_ctl;
        logic [31:0] exp_busy;
        @(negedge clk);
        #1;
        in_flush   = (flush_left > 0);
        frozen     = !mem_ready;
        stall_here = id_valid && !in_flush &&
                     (reads_pending(id_rs1_used, id_rs1n) || reads_pending(id_rs2_used, id_rs2n));
        if (rst)            exp_ctl = 4'b0000;
        else if (frozen)    exp_ctl = 4'b1100;
        else if (in_flush)  exp_ctl = 4'b0001;
        else if (stall_here) exp_ctl = 4'b1110;
        else                exp_ctl = 4'b0000;
        check("ctl", {28'd0, stall_if, stall_id, bubble_ex, flush_if_id}, {28'd0, exp_ctl});

        if (rst) begin
            foreach (pending[i]) pending[i] = 1'b0;
            flush_left = 0;
            stalls = 0;
        end else begin
            if (wb_valid) pending[wb_rdn] = 1'b0;
            if (!frozen) begin
                if (in_flush) flush_left--;
                else if (stall_here) stalls = (stalls < (1 << CW) - 1) ? stalls + 1 : stalls;
                else if (id_valid) begin
                    if (id_is_load && id_rdn != 5'd0) pending[id_rdn] = 1'b1;
                    if (branch_taken) flush_left = FC;
                end
            end
        end
        @(posedge clk);
        #1;
        exp_busy = '0;
        for (int unsigned n = 1; n < 32; n++) exp_busy[n] = pending[n];
        check("busy", busy, exp_busy);
        check("stall_cnt", 32'(stall_cnt), 32'(stalls));
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd);
        idle(); id_valid = 1'b1; id_is_load = 1'b1; id_rdn = rd;
    endtask

    task automatic use_rs1(input logic [4:0] rs);
        idle(); id_valid = 1'b1; id_rs1_used = 1'b1; id_rs1n = rs;
    endtask

    initial begin
        idle();
        flush_left = 0;
        stalls = 0;
        foreach (pending[i]) pending[i] = 1'b0;
        do_reset();
        check("reset_busy", busy, 32'd0);

        // Load-use on x5 stalls until writeback, released the same cycle.
        load(5'd5); step();
        repeat (3) begin use_rs1(5'd5); step(); end
        use_rs1(5'd5); wb_valid = 1'b1; wb_rdn = 5'd5; step();
        check("loaduse_cnt", 32'(stall_cnt), 32'd3);

        // x0 is never tracked.
        load(5'd0); step();
        use_rs1(5'd0); step();
        check("x0_busy", busy, 32'd0);

        // Taken branch: two flush cycles; a branch in the flushed slot is ignored.
        idle(); id_valid = 1'b1; branch_taken = 1'b1; step();
        idle(); id_valid = 1'b1; branch_taken = 1'b1; step();
        idle(); step();
        idle(); step();
        check("flush_done", {31'd0, flush_if_id}, 32'd0);

        // Freeze for three cycles in the middle of a flush.
        idle(); id_valid = 1'b1; branch_taken = 1'b1; step();
        idle(); step();
        repeat (3) begin idle(); mem_ready = 1'b0; step(); end
        idle(); step();
        idle(); step();

        // Set wins over a same-cycle clear of the same register.
        load(5'd7); wb_valid = 1'b1; wb_rdn = 5'd7; step();
        check("x7_set", {31'd0, busy[7]}, 32'd1);
        use_rs1(5'd7); step();
        do_reset();

        // Reset in the middle of a flush with x5 pending.
        load(5'd5); branch_taken = 1'b1; step();
        check("x5_set", busy, 32'h0000_0020);
        idle(); rst = 1'b1; id_valid = 1'b1; id_rs1_used = 1'b1; id_rs1n = 5'd5; step();
        check("rst_busy", busy, 32'd0);
        idle(); step();

        // Saturation of the narrow stall counter.
        load(5'd3); step();
        repeat (20) begin use_rs1(5'd3); step(); end
        check("sat_cnt", 32'(stall_cnt), 32'd15);
        do_reset();

        // Randomized traffic over a small register window to provoke hazards.
        repeat (600) begin
            rst          = ($urandom_range(0, 59) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs1n      = 5'($urandom_range(0, 7));
            id_rs2n      = 5'($urandom_range(0, 7));
            id_rs1_used  = $urandom_range(0, 1) == 1;
            id_rs2_used  = $urandom_range(0, 1) == 1;
            id_rdn       = 5'($urandom_range(0, 7));
            id_is_load   = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            wb_valid     = ($urandom_range(0, 2) == 0);
            wb_rdn       = 5'($urandom_range(0, 7));
            mem_ready    = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
